// File: rtl/mpx_hilo_unit_if.sv
// rtl/mpx_hilo_unit_if.sv - issue, writeback and result signals of the HI/LO unit
interface mpx_hilo_unit_if;
    logic        opcode_valid_i;
    logic [31:0] opcode_opcode_i;
    logic [31:0] opcode_rs_operand_i;
    logic        hold_i;
    logic        mul_wb_valid_i;
    logic [31:0] mul_wb_hi_i;
    logic [31:0] mul_wb_lo_i;
    logic        div_wb_valid_i;
    logic [31:0] div_wb_hi_i;
    logic [31:0] div_wb_lo_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_o;

    modport master (
        output opcode_valid_i, opcode_opcode_i, opcode_rs_operand_i, hold_i,
        output mul_wb_valid_i, mul_wb_hi_i, mul_wb_lo_i,
        output div_wb_valid_i, div_wb_hi_i, div_wb_lo_i,
        input  stall_o, result_valid_o, result_o, hi_o, lo_o, err_o
    );

    modport slave (
        input  opcode_valid_i, opcode_opcode_i, opcode_rs_operand_i, hold_i,
        input  mul_wb_valid_i, mul_wb_hi_i, mul_wb_lo_i,
        input  div_wb_valid_i, div_wb_hi_i, div_wb_lo_i,
        output stall_o, result_valid_o, result_o, hi_o, lo_o, err_o
    );
endinterface

// File: rtl/mpx_hilo_unit.sv
// rtl/mpx_hilo_unit.sv - MIPS HI/LO registers with mult/div writeback tracking and interlock
module mpx_hilo_unit #(
    parameter int MAX_PENDING = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    mpx_hilo_unit_if.slave   bus
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    typedef enum logic {KIND_MUL = 1'b0, KIND_DIV = 1'b1} kind_e;

    logic [CW-1:0] pending_q;
    kind_e         kind_q;
    logic [31:0]   hi_q, lo_q, result_q;
    logic          result_valid_q, err_q;

    logic [5:0] funct;
    logic       special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mf, is_mt, is_md;
    kind_e      new_kind;
    logic       unused_bits;

    assign funct       = bus.opcode_opcode_i[5:0];
    assign special     = (bus.opcode_opcode_i[31:26] == 6'd0);
    assign unused_bits = ^bus.opcode_opcode_i[25:6];
    assign is_mfhi     = special && (funct == 6'h10);
    assign is_mthi     = special && (funct == 6'h11);
    assign is_mflo     = special && (funct == 6'h12);
    assign is_mtlo     = special && (funct == 6'h13);
    assign is_md       = special && (funct[5:2] == 4'b0110);
    assign is_mf       = is_mfhi || is_mflo;
    assign is_mt       = is_mthi || is_mtlo;
    assign new_kind    = funct[1] ? KIND_DIV : KIND_MUL;

    // Writebacks are only consumed while the pipeline is not held.
    logic        mul_take, div_take;
    logic [1:0]  wb_cnt;
    logic [CW:0] pend_ext, cnt_ext;
    logic        underflow;
    logic [CW-1:0] pend_after, pend_next;

    assign mul_take   = bus.mul_wb_valid_i && !bus.hold_i;
    assign div_take   = bus.div_wb_valid_i && !bus.hold_i;
    assign wb_cnt     = {1'b0, mul_take} + {1'b0, div_take};
    assign pend_ext   = {1'b0, pending_q};
    assign cnt_ext    = (CW+1)'(wb_cnt);
    assign underflow  = cnt_ext > pend_ext;
    assign pend_after = underflow ? '0 : CW'(pend_ext - cnt_ext);

    logic stall, accept, wb_err;

    assign stall = bus.opcode_valid_i && (
                       ((is_mf || is_mt) && (pend_after != '0)) ||
                       (is_md && (pending_q == CW'(MAX_PENDING))) ||
                       (is_md && (pend_after != '0) && (kind_q != new_kind)));
    assign accept    = bus.opcode_valid_i && !stall && !bus.hold_i;
    assign pend_next = pend_after + CW'(accept && is_md);
    assign wb_err    = (mul_take && div_take) || underflow;

    // Program order within a cycle: mul writeback, div writeback, then MTHI/MTLO.
    logic [31:0] hi_wb, lo_wb, hi_d, lo_d;

    assign hi_wb = div_take ? bus.div_wb_hi_i : (mul_take ? bus.mul_wb_hi_i : hi_q);
    assign lo_wb = div_take ? bus.div_wb_lo_i : (mul_take ? bus.mul_wb_lo_i : lo_q);
    assign hi_d  = (accept && is_mthi) ? bus.opcode_rs_operand_i : hi_wb;
    assign lo_d  = (accept && is_mtlo) ? bus.opcode_rs_operand_i : lo_wb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q      <= '0;
            kind_q         <= KIND_MUL;
            hi_q           <= '0;
            lo_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else if (!bus.hold_i) begin
            pending_q      <= pend_next;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            result_valid_q <= accept && is_mf;
            if (accept && is_md) kind_q <= new_kind;
            if (accept && is_mf) result_q <= is_mfhi ? hi_wb : lo_wb;
            if (wb_err) err_q <= 1'b1;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.result_valid_o = result_valid_q;
    assign bus.result_o       = result_q;
    assign bus.hi_o           = hi_q;
    assign bus.lo_o           = lo_q;
    assign bus.err_o          = err_q;
endmodule

// File: tb/tb_mpx_hilo_unit.sv
// tb/tb_mpx_hilo_unit.sv - scoreboard bench for mpx_hilo_unit
module tb_mpx_hilo_unit;
    localparam int MAXP = 3;
    localparam int C_NONE = 0, C_MF = 1, C_MT = 2, C_MD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mpx_hilo_unit_if bus();
    mpx_hilo_unit #(.MAX_PENDING(MAXP)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int n_checks = 0;
    int n_err = 0;

    // Architectural model state.
    int          m_pend;
    int          m_kind;
    bit          m_err;
    logic [31:0] m_hi, m_lo;
    logic [31:0] exp_q[$];
    logic        edge_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_class(input logic [31:0] w);
        if (w[31:26] != 6'd0) return C_NONE;
        case (w[5:0])
            6'h10, 6'h12:               return C_MF;
            6'h11, 6'h13:               return C_MT;
            6'h18, 6'h19, 6'h1A, 6'h1B: return C_MD;
            default:                    return C_NONE;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] f);
        logic [31:0] r;
        r = {6'd0, 20'($urandom), f};
        return r;
    endfunction

    always @(posedge clk) edge_hold <= bus.hold_i;

    // Monitor: each freshly produced MF result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.result_valid_o && !edge_hold) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL result_unexpected: got %h expected none", bus.result_o);
            end else begin
                chk("mf_result", bus.result_o, exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        bus.opcode_valid_i = 1'b0;
        bus.opcode_opcode_i = 32'd0;
        bus.opcode_rs_operand_i = 32'd0;
        bus.hold_i = 1'b0;
        bus.mul_wb_valid_i = 1'b0;
        bus.div_wb_valid_i = 1'b0;
    endtask

    task automatic set_op(input logic [5:0] f, input logic [31:0] rs);
        bus.opcode_valid_i = 1'b1;
        bus.opcode_opcode_i = mk(f);
        bus.opcode_rs_operand_i = rs;
    endtask

    task automatic set_mul(input logic [31:0] h, input logic [31:0] l);
        bus.mul_wb_valid_i = 1'b1;
        bus.mul_wb_hi_i = h;
        bus.mul_wb_lo_i = l;
    endtask

    task automatic set_div(input logic [31:0] h, input logic [31:0] l);
        bus.div_wb_valid_i = 1'b1;
        bus.div_wb_hi_i = h;
        bus.div_wb_lo_i = l;
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_kind = 0;
        m_err  = 1'b0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: predict stall before the edge, advance the model, check state after.
    task automatic step();
        int  cnt, pa, c, k;
        bit  wbm, wbd, st, acc, hold;
        @(negedge clk);
        hold = bus.hold_i;
        wbm  = bus.mul_wb_valid_i && !hold;
        wbd  = bus.div_wb_valid_i && !hold;
        cnt  = int'(wbm) + int'(wbd);
        c    = op_class(bus.opcode_opcode_i);
        k    = (bus.opcode_opcode_i[5:0] == 6'h1A || bus.opcode_opcode_i[5:0] == 6'h1B) ? 1 : 0;
        pa   = (m_pend - cnt < 0) ? 0 : m_pend - cnt;
        st   = bus.opcode_valid_i && (((c == C_MF || c == C_MT) && pa != 0) ||
                                      (c == C_MD && m_pend == MAXP) ||
                                      (c == C_MD && pa != 0 && m_kind != k));
        chk("stall", 32'(bus.stall_o), 32'(st));
        acc = bus.opcode_valid_i && !st && !hold;
        if (!hold && ((wbm && wbd) || cnt > m_pend)) m_err = 1'b1;
        if (wbm) begin m_hi = bus.mul_wb_hi_i; m_lo = bus.mul_wb_lo_i; end
        if (wbd) begin m_hi = bus.div_wb_hi_i; m_lo = bus.div_wb_lo_i; end
        if (acc && c == C_MF) exp_q.push_back(bus.opcode_opcode_i[5:0] == 6'h10 ? m_hi : m_lo);
        if (acc && c == C_MT) begin
            if (bus.opcode_opcode_i[5:0] == 6'h11) m_hi = bus.opcode_rs_operand_i;
            else m_lo = bus.opcode_rs_operand_i;
        end
        m_pend = pa + ((acc && c == C_MD) ? 1 : 0);
        if (acc && c == C_MD) m_kind = k;
        @(posedge clk);
        #1;
        chk("hi", bus.hi_o, m_hi);
        chk("lo", bus.lo_o, m_lo);
        chk("err", 32'(bus.err_o), 32'(m_err));
    endtask

    logic [5:0] functs[10];

    initial begin
        functs = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h10};
        bus.mul_wb_hi_i = 32'd0; bus.mul_wb_lo_i = 32'd0;
        bus.div_wb_hi_i = 32'd0; bus.div_wb_lo_i = 32'd0;
        do_reset();
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        chk("rst_rv", 32'(bus.result_valid_o), 32'd0);
        chk("rst_res", bus.result_o, 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);

        // MTHI then MFHI
        set_op(6'h11, 32'h1234); step();
        set_op(6'h10, 32'd0);    step();
        idle();                  step();
        chk("t1_hi", bus.hi_o, 32'h1234);

        // MULT, then MFLO interlocked until the writeback bypasses into the result
        set_op(6'h18, 32'd0); step();
        set_op(6'h12, 32'd0); step(); step();
        set_mul(32'hAAAA_0001, 32'hBBBB_0002); step();
        idle(); step();
        chk("t2_lo", bus.lo_o, 32'hBBBB_0002);

        // Pending limit
        do_reset();
        repeat (3) begin set_op(6'h19, 32'd0); step(); end
        set_op(6'h18, 32'd0); step();
        set_mul(32'd1, 32'd2); step();
        idle(); set_op(6'h18, 32'd0); step();
        chk("t3_stall", 32'(bus.stall_o), 32'd1);

        // Kind change waits for the mul writeback
        do_reset();
        set_op(6'h18, 32'd0); step();
        set_op(6'h1A, 32'd0); step(); step();
        set_mul(32'h9, 32'h8); step();
        idle(); set_div(32'h5, 32'h7); step();
        chk("t4_hi", bus.hi_o, 32'h5);
        chk("t4_lo", bus.lo_o, 32'h7);

        // Simultaneous writebacks and orphan writeback
        do_reset();
        set_op(6'h18, 32'd0); step(); step();
        idle(); set_mul(32'h1, 32'h2); set_div(32'h3, 32'h4); step();
        chk("t5_err", 32'(bus.err_o), 32'd1);
        idle(); step();
        do_reset();
        set_mul(32'h11, 32'h22); step();
        chk("t5_orphan_err", 32'(bus.err_o), 32'd1);

        // Hold for three cycles with a writeback waiting
        do_reset();
        set_op(6'h18, 32'd0); step();
        idle(); set_mul(32'h33, 32'h44); bus.hold_i = 1'b1;
        repeat (3) step();
        bus.hold_i = 1'b0; step();
        idle(); set_op(6'h10, 32'd0); step();
        idle(); step();
        chk("t6_err", 32'(bus.err_o), 32'd0);

        // Asynchronous reset mid-MULT, then a late writeback
        set_op(6'h13, 32'hDEAD_BEEF); step();
        set_op(6'h18, 32'd0); step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("arst_lo", bus.lo_o, 32'd0);
        chk("arst_hi", bus.hi_o, 32'd0);
        chk("arst_err", 32'(bus.err_o), 32'd0);
        chk("arst_rv", 32'(bus.result_valid_o), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        set_mul(32'h5, 32'h6); step();
        idle(); step();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!bus.hold_i) begin
                bus.mul_wb_valid_i = (m_pend > 0) && ($urandom_range(3) == 0);
                bus.div_wb_valid_i = (m_pend > 0) && !bus.mul_wb_valid_i && ($urandom_range(3) == 0);
                if ($urandom_range(127) == 0) bus.mul_wb_valid_i = 1'b1;
                bus.mul_wb_hi_i = $urandom; bus.mul_wb_lo_i = $urandom;
                bus.div_wb_hi_i = $urandom; bus.div_wb_lo_i = $urandom;
            end
            bus.hold_i = ($urandom_range(7) == 0);
            bus.opcode_valid_i = $urandom_range(1);
            bus.opcode_opcode_i = ($urandom_range(15) == 0) ? 32'($urandom) : mk(functs[$urandom_range(9)]);
            bus.opcode_rs_operand_i = $urandom;
            step();
            if (i == 1500) do_reset();
        end
        idle(); step(); step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
